bmp_draw_sched: RTL and testbench

//  Command scheduler in front of the 6-bit bitmap/font placer. Accepts draw commands
//  (add image, remove image, add font glyph) from two requesters: game FSM (port 0)
//  and CPU MMIO (port 1). Arbitrates them round-robin into an 8-deep FIFO, then issues
//  one command at a time to the placer. It launches with a 1-cycle add/rem/fnt pulse
//  and waits for the placer's busy to rise and fall before issuing the next command.

---
 rtl/draw_pkg.sv | 28 ++
 rtl/draw_cmd_fifo.sv | 55 +++++
 rtl/bmp_draw_sched.sv | 155 +++++++++++++++
 tb/tb_bmp_draw_sched.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/draw_pkg.sv
// Shared types for the bitmap/font draw command scheduler.
package draw_pkg;

  localparam int CMD_W = 27;

  typedef enum logic [1:0] {
    OP_NOP     = 2'b00,
    OP_ADD_IMG = 2'b01,
    OP_REM_IMG = 2'b10,
    OP_ADD_FNT = 2'b11
  } draw_op_t;

  // Bit layout matches the requester bus: {op, indx, yloc, xloc}
  typedef struct packed {
    draw_op_t    op;
    logic [5:0]  indx;
    logic [8:0]  yloc;
    logic [9:0]  xloc;
  } draw_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT_HI,
    ST_WAIT_LO
  } sched_state_t;

endpackage

// File: rtl/draw_cmd_fifo.sv
// Synchronous command FIFO; head entry is visible on dout whenever not empty.
module draw_cmd_fifo
  import draw_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  draw_cmd_t              din,
  output draw_cmd_t              dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  draw_cmd_t         mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage write; contents need no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bmp_draw_sched.sv
// Draw command scheduler: round-robin arbitration of two requesters into a
// FIFO, then one-at-a-time issue to the placer with busy handshake.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   IDLE     | no command in flight; pops head when placer is idle
//   LAUNCH   | operands loaded; launch pulse registered for next cycle
//   WAIT_HI  | pulse visible; waiting for placer busy (timeout -> lost)
//   WAIT_LO  | placer working; waiting for busy to drop
module bmp_draw_sched
  import draw_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int TMO_CYC = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             req_vld,
  output logic [1:0]             req_rdy,
  input  logic [CMD_W-1:0]       req0_cmd,
  input  logic [CMD_W-1:0]       req1_cmd,
  input  logic                   plc_busy,
  output logic                   add_img,
  output logic                   rem_img,
  output logic                   add_fnt,
  output logic [4:0]             image_indx,
  output logic [5:0]             fnt_indx,
  output logic [9:0]             xloc,
  output logic [8:0]             yloc,
  output logic [$clog2(DEPTH):0] fifo_cnt,
  output logic                   sched_idle,
  output logic                   cmd_lost
);

  localparam int TMO_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

  draw_cmd_t    cmd0;
  draw_cmd_t    cmd1;
  draw_cmd_t    sel_cmd;
  draw_cmd_t    head;
  draw_cmd_t    cmd_q;
  logic [1:0]   grant;
  logic         prio_q;
  logic         xfer;
  logic         push;
  logic         pop;
  logic         fifo_full;
  logic         fifo_empty;
  sched_state_t state_q;
  sched_state_t state_d;
  logic [TMO_W-1:0] tmo_q;
  logic         add_d;
  logic         rem_d;
  logic         fnt_d;
  logic         lost_d;

  assign cmd0 = req0_cmd;
  assign cmd1 = req1_cmd;

  // Arbiter: single requester wins outright, contention goes to prio_q
  always_comb begin
    grant = req_vld;
    if (&req_vld) grant = prio_q ? 2'b10 : 2'b01;
  end

  assign req_rdy = grant & {2{~fifo_full}};
  assign xfer    = |req_rdy;
  assign sel_cmd = req_rdy[1] ? cmd1 : cmd0;
  // NOPs complete the handshake but are never queued
  assign push    = xfer && (sel_cmd.op != OP_NOP);
  assign pop     = (state_q == ST_IDLE) && !fifo_empty && !plc_busy;

  // Priority flips to the loser after every accepted transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    prio_q <= 1'b0;
    else if (xfer) prio_q <= req_rdy[0];
  end

  draw_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (sel_cmd),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (pop) state_d = ST_LAUNCH;
      ST_LAUNCH:  state_d = ST_WAIT_HI;
      ST_WAIT_HI: begin
        if (plc_busy)               state_d = ST_WAIT_LO;
        else if (tmo_q == TMO_LAST) state_d = ST_IDLE;
      end
      ST_WAIT_LO: if (!plc_busy) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // FSM output decode; results are registered below so pulses are glitch-free
  always_comb begin
    add_d  = (state_q == ST_LAUNCH) && (cmd_q.op == OP_ADD_IMG);
    rem_d  = (state_q == ST_LAUNCH) && (cmd_q.op == OP_REM_IMG);
    fnt_d  = (state_q == ST_LAUNCH) && (cmd_q.op == OP_ADD_FNT);
    lost_d = (state_q == ST_WAIT_HI) && !plc_busy && (tmo_q == TMO_LAST);
  end

  // Busy-rise timeout counter, restarted on every launch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 tmo_q <= '0;
    else if (state_q == ST_LAUNCH)              tmo_q <= '0;
    else if (state_q == ST_WAIT_HI && !plc_busy) tmo_q <= tmo_q + 1'b1;
  end

  // Registered launch / lost pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_img  <= 1'b0;
      rem_img  <= 1'b0;
      add_fnt  <= 1'b0;
      cmd_lost <= 1'b0;
    end else begin
      add_img  <= add_d;
      rem_img  <= rem_d;
      add_fnt  <= fnt_d;
      cmd_lost <= lost_d;
    end
  end

  // Operand register: loaded only on pop, so it is stable while in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cmd_q <= '0;
    else if (pop) cmd_q <= head;
  end

  assign image_indx = cmd_q.indx[4:0];
  assign fnt_indx   = cmd_q.indx;
  assign xloc       = cmd_q.xloc;
  assign yloc       = cmd_q.yloc;
  assign sched_idle = fifo_empty && (state_q == ST_IDLE);

endmodule

// File: tb/tb_bmp_draw_sched.sv
// Directed bench for bmp_draw_sched with a placer model and a command scoreboard.
module tb_bmp_draw_sched;
  import draw_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_vld;
  logic [1:0]  req_rdy;
  draw_cmd_t   req0_cmd;
  draw_cmd_t   req1_cmd;
  logic        plc_busy;
  logic        add_img, rem_img, add_fnt;
  logic [4:0]  image_indx;
  logic [5:0]  fnt_indx;
  logic [9:0]  xloc;
  logic [8:0]  yloc;
  logic [3:0]  fifo_cnt;
  logic        sched_idle;
  logic        cmd_lost;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int launch_cnt = 0;
  int launch_cyc = 0;
  int lost_cnt = 0;
  int lost_cyc = 0;
  int push_cyc = 0;
  int busy_len = 20;
  int plc_mode = 0;          // 0: normal placer, 1: never goes busy
  int bcnt = 0;
  logic force_busy = 1'b0;
  logic model_busy = 1'b0;
  logic model_prio = 1'b0;
  logic prev_pulse = 1'b0;
  logic prev_lost = 1'b0;
  draw_cmd_t exp_q[$];

  assign plc_busy = force_busy | model_busy;

  bmp_draw_sched #(.DEPTH(8), .TMO_CYC(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_vld    (req_vld),
    .req_rdy    (req_rdy),
    .req0_cmd   (req0_cmd),
    .req1_cmd   (req1_cmd),
    .plc_busy   (plc_busy),
    .add_img    (add_img),
    .rem_img    (rem_img),
    .add_fnt    (add_fnt),
    .image_indx (image_indx),
    .fnt_indx   (fnt_indx),
    .xloc       (xloc),
    .yloc       (yloc),
    .fifo_cnt   (fifo_cnt),
    .sched_idle (sched_idle),
    .cmd_lost   (cmd_lost)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic draw_cmd_t mk(draw_op_t op, int indx, int y, int x);
    draw_cmd_t c;
    c.op   = op;
    c.indx = 6'(indx);
    c.yloc = 9'(y);
    c.xloc = 10'(x);
    return c;
  endfunction

  function automatic logic [2:0] onehot(draw_op_t op);
    case (op)
      OP_ADD_IMG: return 3'b100;
      OP_REM_IMG: return 3'b010;
      OP_ADD_FNT: return 3'b001;
      default:    return 3'b000;
    endcase
  endfunction

  // Monitor + placer model: checks each launch against the scoreboard head
  always @(negedge clk) begin
    logic pulse;
    draw_cmd_t e;
    if (!rst_n) begin
      bcnt = 0;
      model_busy = 1'b0;
      prev_pulse = 1'b0;
      prev_lost = 1'b0;
    end else begin
      pulse = add_img | rem_img | add_fnt;
      if (pulse) begin
        launch_cnt++;
        launch_cyc = cyc;
        chk("pulse_while_busy", 32'(plc_busy), 32'd0);
        chk("pulse_width", 32'(prev_pulse), 32'd0);
        if (exp_q.size() == 0) chk("unexpected_launch", 32'(pulse), 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("launch_op", 32'({add_img, rem_img, add_fnt}), 32'(onehot(e.op)));
          chk("launch_x", 32'(xloc), 32'(e.xloc));
          chk("launch_y", 32'(yloc), 32'(e.yloc));
          if (e.op == OP_ADD_FNT) chk("launch_fnt_indx", 32'(fnt_indx), 32'(e.indx));
          else                    chk("launch_img_indx", 32'(image_indx), 32'(e.indx[4:0]));
        end
      end
      if (cmd_lost) begin
        lost_cnt++;
        lost_cyc = cyc;
        chk("lost_width", 32'(prev_lost), 32'd0);
      end
      prev_pulse = pulse;
      prev_lost = cmd_lost;
      if (bcnt > 0) bcnt--;
      if (pulse && plc_mode == 0) bcnt = busy_len;
      model_busy = (bcnt > 0);
    end
  end

  // One cycle of requester drive; transfers are scored into the queue
  task automatic step(input logic v0, input draw_cmd_t c0, input logic v1, input draw_cmd_t c1,
                      output logic [1:0] rdy_s);
    draw_cmd_t c;
    @(negedge clk);
    req_vld = {v1, v0};
    req0_cmd = c0;
    req1_cmd = c1;
    #1;
    rdy_s = req_rdy;
    if (v0 && v1 && req_rdy != 2'b00)
      chk("arb_winner", 32'(req_rdy), model_prio ? 32'd2 : 32'd1);
    if ((req_vld & req_rdy) != 2'b00) begin
      c = req_rdy[1] ? c1 : c0;
      if (c.op != OP_NOP) exp_q.push_back(c);
      model_prio = req_rdy[0];
      push_cyc = cyc + 1;
    end
  endtask

  task automatic wait_launches(input int n, input int bound, input string tag);
    logic ok;
    ok = 1'b0;
    for (int c = 0; c < bound; c++) begin
      @(negedge clk); #2;
      if (launch_cnt >= n) begin ok = 1'b1; break; end
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  task automatic wait_drain(input int bound, input string tag);
    logic ok;
    ok = 1'b0;
    for (int c = 0; c < bound; c++) begin
      @(negedge clk); #2;
      if (sched_idle && !plc_busy && exp_q.size() == 0) begin ok = 1'b1; break; end
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_rdy"}, 32'(req_rdy), 32'd0);
    chk({p, "_pulses"}, 32'({add_img, rem_img, add_fnt}), 32'd0);
    chk({p, "_img_indx"}, 32'(image_indx), 32'd0);
    chk({p, "_fnt_indx"}, 32'(fnt_indx), 32'd0);
    chk({p, "_xy"}, 32'({yloc, xloc}), 32'd0);
    chk({p, "_fifo_cnt"}, 32'(fifo_cnt), 32'd0);
    chk({p, "_sched_idle"}, 32'(sched_idle), 32'd1);
    chk({p, "_cmd_lost"}, 32'(cmd_lost), 32'd0);
  endtask

  initial begin
    draw_cmd_t z;
    draw_cmd_t p0[6];
    draw_cmd_t p1[6];
    logic [1:0] r;
    logic ok;
    int n0, i0, i1, n;
    int grants[$];

    z = '0;
    rst_n = 1'b0;
    req_vld = 2'b00;
    req0_cmd = '0;
    req1_cmd = '0;
    repeat (3) @(negedge clk);
    #1 chk_reset("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // 1: single ADD_IMG, latency and idle return
    busy_len = 20;
    n0 = launch_cnt;
    step(1'b1, mk(OP_ADD_IMG, 1, 50, 100), 1'b0, z, r);
    chk("t1_rdy", 32'(r), 32'd1);
    step(1'b0, z, 1'b0, z, r);
    wait_launches(n0 + 1, 20, "t1_launch");
    chk("t1_latency", 32'(launch_cyc - push_cyc), 32'd2);
    chk("t1_busy_seen", 32'(plc_busy), 32'd1);
    chk("t1_not_idle", 32'(sched_idle), 32'd0);
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); #2;
      if (!plc_busy) begin ok = 1'b1; break; end
    end
    chk("t1_busy_fall", 32'(ok), 32'd1);
    @(posedge clk); #1;
    chk("t1_idle_after", 32'(sched_idle), 32'd1);

    // 5: NOP on port 1 is accepted but never queued or launched
    n0 = launch_cnt;
    step(1'b0, z, 1'b1, mk(OP_NOP, 3, 3, 3), r);
    chk("t5_rdy", 32'(r), 32'd2);
    step(1'b0, z, 1'b0, z, r);
    chk("t5_fifo_cnt", 32'(fifo_cnt), 32'd0);
    repeat (10) @(negedge clk);
    #2 chk("t5_no_launch", 32'(launch_cnt), 32'(n0));

    // 2: both ports valid continuously, grants alternate starting at port 0
    busy_len = 2;
    n0 = launch_cnt;
    for (int k = 0; k < 6; k++) begin
      p0[k] = mk((k % 2) ? OP_REM_IMG : OP_ADD_IMG, k + 1, 10 + k, 20 + k);
      p1[k] = mk(OP_ADD_FNT, 30 + k, 200 + k, 600 + k);
    end
    i0 = 0;
    i1 = 0;
    for (int c = 0; c < 600 && (i0 < 6 || i1 < 6); c++) begin
      step(i0 < 6, p0[i0 % 6], i1 < 6, p1[i1 % 6], r);
      if (r[0] && i0 < 6) begin grants.push_back(0); i0++; end
      else if (r[1] && i1 < 6) begin grants.push_back(1); i1++; end
    end
    step(1'b0, z, 1'b0, z, r);
    chk("t2_all_sent", 32'(i0 + i1), 32'd12);
    for (int k = 0; k < grants.size(); k++) chk("t2_grant_order", 32'(grants[k]), 32'(k % 2));
    wait_drain(600, "t2_drain");
    chk("t2_launches", 32'(launch_cnt - n0), 32'd12);

    // 3: fill FIFO with busy stuck high, then drain in order
    @(negedge clk);
    force_busy = 1'b1;
    n0 = launch_cnt;
    n = 0;
    for (int c = 0; c < 30 && n < 8; c++) begin
      step(1'b1, mk(OP_ADD_IMG, n, 100 + n, 500 + n), 1'b0, z, r);
      if (r[0]) n++;
    end
    step(1'b1, mk(OP_REM_IMG, 9, 9, 9), 1'b1, mk(OP_ADD_FNT, 9, 9, 9), r);
    chk("t3_rdy_full", 32'(r), 32'd0);
    chk("t3_fifo_full", 32'(fifo_cnt), 32'd8);
    step(1'b0, z, 1'b0, z, r);
    busy_len = 3;
    force_busy = 1'b0;
    wait_drain(400, "t3_drain");
    chk("t3_fifo_empty", 32'(fifo_cnt), 32'd0);
    chk("t3_launches", 32'(launch_cnt - n0), 32'd8);

    // 4: placer never goes busy -> cmd_lost 4 cycles after launch
    plc_mode = 1;
    n0 = lost_cnt;
    step(1'b1, mk(OP_ADD_FNT, 41, 7, 9), 1'b0, z, r);
    step(1'b0, z, 1'b0, z, r);
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); #2;
      if (lost_cnt > n0) begin ok = 1'b1; break; end
    end
    chk("t4_lost_seen", 32'(ok), 32'd1);
    chk("t4_lost_delay", 32'(lost_cyc - launch_cyc), 32'd4);
    plc_mode = 0;
    n0 = launch_cnt;
    step(1'b1, mk(OP_REM_IMG, 5, 300, 400), 1'b0, z, r);
    step(1'b0, z, 1'b0, z, r);
    wait_launches(n0 + 1, 30, "t4_next_issue");
    wait_drain(60, "t4_drain");

    // 6: reset asserted in WAIT_LO with three commands queued
    busy_len = 20;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, mk(OP_ADD_IMG, 10 + k, 40 + k, 60 + k), 1'b0, z, r);
      chk("t6_accept", 32'(r), 32'd1);
    end
    step(1'b0, z, 1'b0, z, r);
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk); #2;
      if (fifo_cnt == 4'd3 && plc_busy) begin ok = 1'b1; break; end
    end
    chk("t6_in_flight", 32'(ok), 32'd1);
    repeat (3) @(negedge clk);
    #1 chk("t6_queued", 32'(fifo_cnt), 32'd3);
    rst_n = 1'b0;
    #1 chk_reset("t6_rst");
    exp_q.delete();
    model_prio = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n0 = launch_cnt;
    repeat (30) @(negedge clk);
    #2;
    chk("t6_no_launch", 32'(launch_cnt), 32'(n0));
    chk("t6_fifo_cnt", 32'(fifo_cnt), 32'd0);
    chk("t6_sched_idle", 32'(sched_idle), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
